// File: rtl/uart_tx_pkg.sv
// Shared register map, bit positions and FSM state type for the MMIO UART transmitter.
package uart_tx_pkg;

    localparam logic [3:0] OFF_TXDATA = 4'h0;
    localparam logic [3:0] OFF_STATUS = 4'h4;
    localparam logic [3:0] OFF_CTRL   = 4'h8;

    localparam int unsigned STAT_FULL    = 0;
    localparam int unsigned STAT_EMPTY   = 1;
    localparam int unsigned STAT_BUSY    = 2;
    localparam int unsigned STAT_OVERRUN = 3;
    localparam int unsigned STAT_CNT_LSB = 8;

    localparam int unsigned CTRL_FLUSH   = 0;
    localparam int unsigned CTRL_CLR_OVR = 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head entry is presented on dout while non-empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign count = wptr - rptr;
    assign dout  = mem[rptr[AW-1:0]];

    // A pop frees the head slot on the same edge, so a push while full is still accepted.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (flush) begin
                rptr <= do_push ? wptr + 1'b1 : wptr;
            end else if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS/CTRL window, TX FIFO and serialiser FSM.
module mmio_uart_tx
    import uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0400,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        sel,
    output logic        tx,
    output logic        busy
);

    localparam int unsigned CW  = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned FCW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;
    logic            overrun;

    logic            wr;
    logic            push;
    logic            pop;
    logic            flush;
    logic            clr_ovr;
    logic [7:0]      dout;
    logic            full;
    logic            empty;
    logic [FCW-1:0]  count;
    logic [31:0]     status;
    logic            unused;

    assign unused = ^{wd[31:8], a[1:0]};

    assign sel     = (a[31:4] == BASE_ADDR[31:4]) && (a[3:2] != 2'b11);
    assign wr      = we && sel;
    assign push    = wr && (a[3:2] == OFF_TXDATA[3:2]);
    assign flush   = wr && (a[3:2] == OFF_CTRL[3:2]) && wd[CTRL_FLUSH];
    assign clr_ovr = wr && (a[3:2] == OFF_CTRL[3:2]) && wd[CTRL_CLR_OVR];

    // Pops only at frame boundaries; a flush on the same edge suppresses the start of a new frame.
    assign pop  = !empty && !flush && ((state == IDLE) || ((state == STOP) && (cnt == '0)));
    assign busy = !empty || (state != IDLE);

    always_comb begin
        status                             = '0;
        status[STAT_FULL]                  = full;
        status[STAT_EMPTY]                 = empty;
        status[STAT_BUSY]                  = busy;
        status[STAT_OVERRUN]               = overrun;
        status[STAT_CNT_LSB +: 8]          = 8'(count);
    end

    assign rd = (sel && (a[3:2] == OFF_STATUS[3:2])) ? status : 32'h0;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (wd[7:0]),
        .dout  (dout),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (push && full && !pop) begin
            overrun <= 1'b1;
        end else if (clr_ovr) begin
            overrun <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        shift <= dout;
                        cnt   <= CNT_MAX;
                        state <= START;
                        tx    <= 1'b0;
                    end
                end
                START: begin
                    if (cnt == '0) begin
                        cnt     <= CNT_MAX;
                        bit_idx <= '0;
                        state   <= DATA;
                        tx      <= shift[0];
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == '0) begin
                        cnt <= CNT_MAX;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            shift   <= shift >> 1;
                            tx      <= shift[1];
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == '0) begin
                        if (pop) begin
                            shift <= dout;
                            cnt   <= CNT_MAX;
                            state <= START;
                            tx    <= 1'b0;
                        end else begin
                            state <= IDLE;
                            tx    <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed self-checking bench for mmio_uart_tx with default parameters (16 clks/bit, depth 8).
module tb_mmio_uart_tx;

    logic        clk;
    logic        reset;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        sel;
    logic        tx;
    logic        busy;

    int unsigned checks;
    int unsigned errors;
    int unsigned edge_cnt;
    int unsigned base;
    logic [7:0]  exp_bits;

    mmio_uart_tx dut (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .a     (a),
        .wd    (wd),
        .rd    (rd),
        .sel   (sel),
        .tx    (tx),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs set before the next rising edge, held across it; returns at the following negedge.
    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        we = 1'b1;
        a  = addr;
        wd = data;
        @(negedge clk);
        we = 1'b0;
        wd = 32'h0;
    endtask

    task automatic read_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        we = 1'b0;
        a  = addr;
        #1;
        check(tag, rd, exp);
    endtask

    task automatic wait_until(input int unsigned e);
        while (edge_cnt < e) @(negedge clk);
    endtask

    task automatic wait_idle(input string tag);
        int unsigned n;
        n = 0;
        while (busy !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'h0, busy}, 32'h0);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        edge_cnt = 0;
        reset    = 1'b1;
        we       = 1'b0;
        a        = 32'h0;
        wd       = 32'h0;

        // Reset then idle
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_tx", {31'h0, tx}, 32'h1);
        check("rst_busy", {31'h0, busy}, 32'h0);
        read_chk("rst_status", 32'h404, 32'h0000_0002);
        check("rst_sel", {31'h0, sel}, 32'h1);

        // Asynchronous reset mid-frame
        base = edge_cnt + 1;
        bus_write(32'h400, 32'hFF);
        bus_write(32'h400, 32'h12);
        wait_until(base + 3);
        check("pre_arst_tx", {31'h0, tx}, 32'h0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("arst_tx", {31'h0, tx}, 32'h1);
        check("arst_busy", {31'h0, busy}, 32'h0);
        read_chk("arst_status", 32'h404, 32'h0000_0002);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        read_chk("post_arst_status", 32'h404, 32'h0000_0002);

        // Single byte 0xA5
        exp_bits = 8'b1010_0101;
        base = edge_cnt + 1;
        bus_write(32'h400, 32'h0000_00A5);
        check("a5_tx_n", {31'h0, tx}, 32'h1);
        check("a5_busy_n", {31'h0, busy}, 32'h1);
        wait_until(base + 1);
        check("a5_start_edge", {31'h0, tx}, 32'h0);
        wait_until(base + 16);
        check("a5_start_last", {31'h0, tx}, 32'h0);
        for (int k = 0; k < 8; k++) begin
            wait_until(base + 25 + 16 * k);
            check($sformatf("a5_bit%0d", k), {31'h0, tx}, {31'h0, exp_bits[k]});
        end
        wait_until(base + 153);
        check("a5_stop", {31'h0, tx}, 32'h1);
        wait_until(base + 160);
        check("a5_busy_last", {31'h0, busy}, 32'h1);
        wait_until(base + 161);
        check("a5_busy_fall", {31'h0, busy}, 32'h0);
        check("a5_tx_idle", {31'h0, tx}, 32'h1);

        // Back-to-back 0x55, 0x0F
        base = edge_cnt + 1;
        bus_write(32'h400, 32'h55);
        bus_write(32'h400, 32'h0F);
        wait_until(base + 25);
        check("b2b_f1_bit0", {31'h0, tx}, 32'h1);
        wait_until(base + 41);
        check("b2b_f1_bit1", {31'h0, tx}, 32'h0);
        wait_until(base + 160);
        check("b2b_f1_stop_last", {31'h0, tx}, 32'h1);
        wait_until(base + 161);
        check("b2b_f2_start", {31'h0, tx}, 32'h0);
        check("b2b_busy_gap", {31'h0, busy}, 32'h1);
        wait_until(base + 185);
        check("b2b_f2_bit0", {31'h0, tx}, 32'h1);
        wait_until(base + 249);
        check("b2b_f2_bit4", {31'h0, tx}, 32'h0);
        wait_until(base + 320);
        check("b2b_busy_last", {31'h0, busy}, 32'h1);
        wait_until(base + 321);
        check("b2b_busy_fall", {31'h0, busy}, 32'h0);

        // Full and overrun
        base = edge_cnt + 1;
        for (int i = 0; i < 10; i++) begin
            bus_write(32'h400, 32'h10 + i);
        end
        read_chk("ovr_status", 32'h404, 32'h0000_080D);
        bus_write(32'h408, 32'h2);
        read_chk("ovr_clear", 32'h404, 32'h0000_0805);
        // Push on the same edge the finished frame pops: accepted while full, no overrun
        wait_until(base + 160);
        bus_write(32'h400, 32'h77);
        read_chk("full_push_pop", 32'h404, 32'h0000_0805);
        check("full_next_start", {31'h0, tx}, 32'h0);
        bus_write(32'h408, 32'h1);
        read_chk("full_flush", 32'h404, 32'h0000_0006);
        wait_idle("full_drain");
        read_chk("full_end_status", 32'h404, 32'h0000_0002);

        // Flush mid-frame
        exp_bits = 8'b0011_1100;
        base = edge_cnt + 1;
        bus_write(32'h400, 32'h3C);
        bus_write(32'h400, 32'h81);
        bus_write(32'h400, 32'h82);
        bus_write(32'h400, 32'h83);
        read_chk("fl_count", 32'h404, 32'h0000_0304);
        wait_until(base + 40);
        bus_write(32'h408, 32'h1);
        read_chk("fl_status", 32'h404, 32'h0000_0006);
        for (int k = 2; k < 8; k++) begin
            wait_until(base + 25 + 16 * k);
            check($sformatf("fl_bit%0d", k), {31'h0, tx}, {31'h0, exp_bits[k]});
        end
        wait_until(base + 153);
        check("fl_stop", {31'h0, tx}, 32'h1);
        wait_until(base + 161);
        check("fl_busy_fall", {31'h0, busy}, 32'h0);
        wait_until(base + 220);
        check("fl_no_frame", {31'h0, tx}, 32'h1);
        read_chk("fl_end_status", 32'h404, 32'h0000_0002);

        // Decode
        we = 1'b1;
        a  = 32'h40C;
        wd = 32'h0000_00FF;
        #1;
        check("dec_40c_sel", {31'h0, sel}, 32'h0);
        check("dec_40c_rd", rd, 32'h0);
        @(negedge clk);
        a  = 32'h500;
        wd = 32'h0000_00A5;
        #1;
        check("dec_500_sel", {31'h0, sel}, 32'h0);
        check("dec_500_rd", rd, 32'h0);
        @(negedge clk);
        we = 1'b0;
        bus_write(32'h404, 32'hFFFF_FFFF);
        read_chk("dec_410_rd", 32'h410, 32'h0);
        check("dec_410_sel", {31'h0, sel}, 32'h0);
        read_chk("dec_400_rd", 32'h400, 32'h0);
        check("dec_400_sel", {31'h0, sel}, 32'h1);
        read_chk("dec_408_rd", 32'h408, 32'h0);
        @(negedge clk);
        check("dec_busy", {31'h0, busy}, 32'h0);
        check("dec_tx", {31'h0, tx}, 32'h1);
        read_chk("dec_status", 32'h404, 32'h0000_0002);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
